spindle_ready_seq: RTL and testbench
====================================

// Module: spindle_ready_seq
// PURPOSE
// Sequences the spindle motor and generates the FDC Ready line (pin 34) for the drive.
// Starts the spindle on a motor-on request with a disk present, then times index pulses
// to confirm rotational speed for the selected density (300/360 rpm) before asserting
// Ready. Drops Ready on speed loss and drops the spindle on spin-up timeout.
// Sits between the FDC bus/sensor inputs and the spindle driver, beside the stepper driver.
// PARAMETERS
// TICK_DIV    500     clk cycles per timing tick (50 MHz -> 10 us tick)
// P300_MIN    19000   min index period, ticks, spin_ss=0 (300 rpm nominal 20000)
// P300_MAX    21000   max index period, ticks, spin_ss=0
// P360_MIN    15833   min index period, ticks, spin_ss=1 (360 rpm nominal 16667)
// P360_MAX    17500   max index period, ticks, spin_ss=1
// SPINUP_TO   100000  spin-up timeout, ticks (1 s)
// GOOD_REVS   2       consecutive in-window periods required for lock
// PORTS
// clk         in   1  system clock
// rst         in   1  asynchronous reset, active-low
// motor_on_n  in   1  FDC motor-on, active-low (pin 16)
// spin_ss     in   1  speed select, 1=360 rpm, 0=300 rpm (synchronous to clk)
// drv_en      in   1  drive selected (active-high, decoded upstream)
// ind_sens    in   1  raw index sensor, low = hole present (asynchronous)
// dsk_sens    in   1  disk-present sensor, high = present (asynchronous)
// spin_en     out  1  spindle motor enable
// ready_n     out  1  FDC Ready, active-low, gated by drv_en
// speed_ok    out  1  high while locked
// fault       out  1  spin-up timeout latched
// BEHAVIOUR
// - Reset: state=IDLE; spin_en=0, ready_n=1, speed_ok=0, fault=0; all counters 0.
// - ind_sens, dsk_sens, motor_on_n: 2-FF synchronizers. Index event = 1-clk pulse on
//   synchronized ind_sens falling edge. spin_ss registered once for change detect.
// - Tick: prescaler counts 0..TICK_DIV-1, tick pulse at wrap. Period counter (17b)
//   increments per tick, saturates at 2^17-1. Timeout counter (17b) likewise.
// - Window W = [P360_MIN,P360_MAX] if spin_ss else [P300_MIN,P300_MAX], inclusive.
// - All outputs registered; state-derived outputs valid the clk after the transition.
// - "req" = motor_on_n==0 AND dsk_sens==1 (synchronized). !req has top priority in
//   SPINUP/LOCKED: -> IDLE same edge, all counters cleared.
// - IDLE: spin_en=0. req -> SPINUP; clear period, timeout, good_cnt; armed=0.
// - SPINUP: spin_en=1. On index event: if !armed, armed=1 (no measurement);
//   else if period in W, good_cnt++, else good_cnt=0. Period cleared on every index
//   event (to 0, even if tick coincides). good_cnt reaching GOOD_REVS -> LOCKED.
//   Timeout counter reaching SPINUP_TO -> FAULT. Lock and timeout same clk: lock wins.
//   spin_ss change: good_cnt=0, armed=0, timeout not restarted.
// - LOCKED: spin_en=1, speed_ok=1. Index with period outside W, or period counter
//   exceeding window max without index, or spin_ss change -> SPINUP with good_cnt=0,
//   armed=1 (armed=0 on spin_ss change), timeout cleared.
// - FAULT: spin_en=0, fault=1. Leaves only when motor_on_n==1 -> IDLE (fault clears);
//   disk removal alone does not clear it.
// - ready_n = ~(state==LOCKED & drv_en), registered; spin_en independent of drv_en.
// - Reset assertion mid-operation forces reset values immediately (asynchronous).
// TESTING (bench overrides: TICK_DIV=4, P300=[90,110], P360=[75,90], SPINUP_TO=500)
// 1 Reset: rst=0 -> spin_en=0, ready_n=1, speed_ok=0, fault=0; release, no req -> unchanged.
// 2 Lock 300: motor_on_n=0, dsk=1, drv_en=1, index every 100 ticks -> spin_en=1 within
//   4 clk; speed_ok=1 and ready_n=0 after 3rd index edge; drv_en=0 -> ready_n=1, speed_ok=1.
// 3 Timeout: req, no index -> fault=1, spin_en=0 at tick 500; motor_on_n=1 -> IDLE, fault=0.
// 4 Speed loss: locked at 100-tick period, next period 130 -> SPINUP at tick 111 (no index),
//   ready_n=1; resume 100-tick index -> relock after 2 good periods.
// 5 Density switch: locked at 300, spin_ss 0->1 -> ready_n=1 next clk; index every 82 ticks
//   -> relock after arm + 2 periods; period 100 at spin_ss=1 never locks.
// 6 Disk pulled mid-SPINUP: dsk_sens=0 -> IDLE, spin_en=0 after sync (<=4 clk), no fault.

Source files
------------

// File: rtl/spindle_ready_seq_if.sv
// Signal bundle between the FDC bus / drive sensors and the spindle ready sequencer.
// Level semantics: ready_n is valid every clock (low = drive locked and selected); no transfer handshake.
interface spindle_ready_seq_if;
  logic       motor_on_n;
  logic       spin_ss;
  logic       drv_en;
  logic       ind_sens;
  logic       dsk_sens;
  logic       spin_en;
  logic       ready_n;
  logic       speed_ok;
  logic       fault;
  logic [1:0] state_dbg;

  modport master (
    output motor_on_n, spin_ss, drv_en, ind_sens, dsk_sens,
    input  spin_en, ready_n, speed_ok, fault, state_dbg
  );

  modport slave (
    input  motor_on_n, spin_ss, drv_en, ind_sens, dsk_sens,
    output spin_en, ready_n, speed_ok, fault, state_dbg
  );
endinterface

// File: rtl/spindle_ready_seq.sv
// Spindle motor sequencer: spins up on motor-on with a disk present, confirms speed
// from index pulse periods, drives the FDC Ready line, and latches a spin-up timeout.
module spindle_ready_seq #(
  parameter int TICK_DIV  = 500,
  parameter int P300_MIN  = 19000,
  parameter int P300_MAX  = 21000,
  parameter int P360_MIN  = 15833,
  parameter int P360_MAX  = 17500,
  parameter int SPINUP_TO = 100000,
  parameter int GOOD_REVS = 2
) (
  input logic               clk,
  input logic               rst,
  spindle_ready_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPINUP = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam int CW = 17;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GOOD_REVS + 1);

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] W300_MIN   = CW'(P300_MIN);
  localparam logic [CW-1:0] W300_MAX   = CW'(P300_MAX);
  localparam logic [CW-1:0] W360_MIN   = CW'(P360_MIN);
  localparam logic [CW-1:0] W360_MAX   = CW'(P360_MAX);
  localparam logic [CW-1:0] TO_LIM     = CW'(SPINUP_TO);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GOOD_LIM   = GW'(GOOD_REVS);

  state_t          state, state_next;
  logic [1:0]      ind_sync, dsk_sync, mon_sync;
  logic            ind_prev, ss_q;
  logic [PW-1:0]   presc;
  logic [CW-1:0]   period_cnt, timeout_cnt;
  logic [GW-1:0]   good_cnt, good_next;
  logic            armed, armed_next;
  logic            per_clr, to_clr;
  logic            spin_en_q, ready_n_q, speed_ok_q, fault_q;

  logic            index_evt, req, ss_chg, tick;
  logic [CW-1:0]   win_min, win_max;
  logic            in_win, over_max;

  // Sensors idle high (no hole) / motor off, so the index edge detector starts quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ind_sync <= 2'b11;
      dsk_sync <= 2'b00;
      mon_sync <= 2'b11;
      ind_prev <= 1'b1;
      ss_q     <= 1'b0;
    end else begin
      ind_sync <= {ind_sync[0], bus.ind_sens};
      dsk_sync <= {dsk_sync[0], bus.dsk_sens};
      mon_sync <= {mon_sync[0], bus.motor_on_n};
      ind_prev <= ind_sync[1];
      ss_q     <= bus.spin_ss;
    end
  end

  assign index_evt = ind_prev & ~ind_sync[1];
  assign req       = ~mon_sync[1] & dsk_sync[1];
  assign ss_chg    = ss_q ^ bus.spin_ss;
  assign tick      = (presc == PRESC_LAST);

  assign win_min  = bus.spin_ss ? W360_MIN : W300_MIN;
  assign win_max  = bus.spin_ss ? W360_MAX : W300_MAX;
  assign in_win   = (period_cnt >= win_min) && (period_cnt <= win_max);
  assign over_max = (period_cnt > win_max);

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    armed_next = armed;
    per_clr    = 1'b0;
    to_clr     = 1'b0;
    case (state)
      IDLE: begin
        per_clr    = 1'b1;
        to_clr     = 1'b1;
        good_next  = '0;
        armed_next = 1'b0;
        if (req) state_next = SPINUP;
      end
      SPINUP: begin
        if (!req) begin
          state_next = IDLE;
          per_clr    = 1'b1;
          to_clr     = 1'b1;
          good_next  = '0;
          armed_next = 1'b0;
        end else begin
          if (ss_chg) begin
            good_next  = '0;
            armed_next = 1'b0;
          end else if (index_evt) begin
            // The first index after arming only starts a clean period.
            per_clr = 1'b1;
            if (!armed)      armed_next = 1'b1;
            else if (in_win) good_next  = good_cnt + GW'(1);
            else             good_next  = '0;
          end
          if (good_next == GOOD_LIM)     state_next = LOCKED;
          else if (timeout_cnt >= TO_LIM) state_next = FAULT;
        end
      end
      LOCKED: begin
        if (!req) begin
          state_next = IDLE;
          per_clr    = 1'b1;
          to_clr     = 1'b1;
          good_next  = '0;
          armed_next = 1'b0;
        end else if (ss_chg) begin
          state_next = SPINUP;
          to_clr     = 1'b1;
          good_next  = '0;
          armed_next = 1'b0;
        end else if (index_evt) begin
          per_clr = 1'b1;
          if (!in_win) begin
            state_next = SPINUP;
            to_clr     = 1'b1;
            good_next  = '0;
            armed_next = 1'b1;
          end
        end else if (over_max) begin
          state_next = SPINUP;
          to_clr     = 1'b1;
          good_next  = '0;
          armed_next = 1'b1;
        end
      end
      FAULT: begin
        per_clr    = 1'b1;
        to_clr     = 1'b1;
        good_next  = '0;
        armed_next = 1'b0;
        if (mon_sync[1]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      good_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      armed    <= armed_next;
    end
  end

  // Prescaler free-runs; period and timeout counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc       <= '0;
      period_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (per_clr)
        period_cnt <= '0;
      else if (tick && (state == SPINUP || state == LOCKED) && period_cnt != CNT_MAX)
        period_cnt <= period_cnt + CW'(1);
      if (to_clr)
        timeout_cnt <= '0;
      else if (tick && state == SPINUP && timeout_cnt != CNT_MAX)
        timeout_cnt <= timeout_cnt + CW'(1);
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spin_en_q  <= 1'b0;
      ready_n_q  <= 1'b1;
      speed_ok_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      spin_en_q  <= (state_next == SPINUP) || (state_next == LOCKED);
      ready_n_q  <= ~((state_next == LOCKED) && bus.drv_en);
      speed_ok_q <= (state_next == LOCKED);
      fault_q    <= (state_next == FAULT);
    end
  end

  assign bus.spin_en   = spin_en_q;
  assign bus.ready_n   = ready_n_q;
  assign bus.speed_ok  = speed_ok_q;
  assign bus.fault     = fault_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_spindle_ready_seq.sv
// Bench for spindle_ready_seq with shortened timing (4-clk tick, 500-tick timeout).
// Output vector compared is {spin_en, ready_n, speed_ok, fault}.
module tb_spindle_ready_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spindle_ready_seq_if u_if();

  spindle_ready_seq #(
    .TICK_DIV(4), .P300_MIN(90), .P300_MAX(110), .P360_MIN(75), .P360_MAX(90),
    .SPINUP_TO(500), .GOOD_REVS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  wire [3:0] outs = {u_if.spin_en, u_if.ready_n, u_if.speed_ok, u_if.fault};

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idx_pulse();
    u_if.ind_sens = 1'b0;
    wait_clk(4);
    u_if.ind_sens = 1'b1;
  endtask

  task automatic go_idle();
    u_if.motor_on_n = 1'b1;
    u_if.dsk_sens   = 1'b0;
    u_if.spin_ss    = 1'b0;
    u_if.drv_en     = 1'b1;
    u_if.ind_sens   = 1'b1;
    wait_clk(8);
  endtask

  // Locks at 300 rpm; returns 8 clocks after the start of the third index pulse.
  task automatic lock_300();
    u_if.motor_on_n = 1'b0;
    u_if.dsk_sens   = 1'b1;
    u_if.drv_en     = 1'b1;
    u_if.spin_ss    = 1'b0;
    wait_clk(6);
    idx_pulse(); wait_clk(396);
    idx_pulse(); wait_clk(396);
    idx_pulse(); wait_clk(4);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    u_if.motor_on_n = 1'b1; u_if.dsk_sens = 1'b0; u_if.spin_ss = 1'b0;
    u_if.drv_en = 1'b0; u_if.ind_sens = 1'b1;
    exp_q.push_back(4'b0100);
    wait_clk(3);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL reset_out: got %b want %b", outs, exp_v); end
    n_cmp++;
    if (u_if.state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", u_if.state_dbg); end
    rst = 1'b1;
    exp_q.push_back(4'b0100);
    wait_clk(10);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL reset_release: got %b want %b", outs, exp_v); end
  endtask

  task automatic test_lock_300();
    u_if.motor_on_n = 1'b0; u_if.dsk_sens = 1'b1; u_if.drv_en = 1'b1;
    exp_q.push_back(4'b1100);
    wait_clk(4);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL spinup_start: got %b want %b", outs, exp_v); end
    idx_pulse(); wait_clk(396);
    idx_pulse(); wait_clk(396);
    exp_q.push_back(4'b1100);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL pre_lock_300: got %b want %b", outs, exp_v); end
    idx_pulse();
    exp_q.push_back(4'b1010);
    wait_clk(4);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL lock_300: got %b want %b", outs, exp_v); end
    n_cmp++;
    if (u_if.state_dbg !== 2'd2) begin n_err++; $display("FAIL lock_300_state: got %0d want 2", u_if.state_dbg); end
    u_if.drv_en = 1'b0;
    exp_q.push_back(4'b1110);
    wait_clk(2);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL drv_deselect: got %b want %b", outs, exp_v); end
    u_if.drv_en = 1'b1;
    exp_q.push_back(4'b1010);
    wait_clk(2);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL drv_reselect: got %b want %b", outs, exp_v); end
    go_idle();
    exp_q.push_back(4'b0100);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL motor_off_idle: got %b want %b", outs, exp_v); end
  endtask

  task automatic test_timeout();
    int cyc;
    cyc = 0;
    u_if.motor_on_n = 1'b0; u_if.dsk_sens = 1'b1; u_if.ind_sens = 1'b1;
    exp_q.push_back(4'b1100);
    wait_clk(4); cyc = 4;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL timeout_spinup: got %b want %b", outs, exp_v); end
    while (cyc < 2300 && u_if.fault !== 1'b1) begin
      wait_clk(1); cyc++;
    end
    n_cmp++;
    if (cyc < 1995 || cyc > 2012) begin n_err++; $display("FAIL timeout_time: got %0d clk want 1995..2012", cyc); end
    exp_q.push_back(4'b0101);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL timeout_fault: got %b want %b", outs, exp_v); end
    u_if.dsk_sens = 1'b0;
    exp_q.push_back(4'b0101);
    wait_clk(10);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL fault_hold_disk: got %b want %b", outs, exp_v); end
    u_if.motor_on_n = 1'b1;
    exp_q.push_back(4'b0100);
    wait_clk(6);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL fault_clear: got %b want %b", outs, exp_v); end
    go_idle();
  endtask

  task automatic test_speed_loss();
    lock_300();
    exp_q.push_back(4'b1010);
    wait_clk(412);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL loss_still_locked: got %b want %b", outs, exp_v); end
    exp_q.push_back(4'b1100);
    wait_clk(50);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL loss_overrun: got %b want %b", outs, exp_v); end
    wait_clk(50);
    idx_pulse(); wait_clk(396);
    exp_q.push_back(4'b1100);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL loss_first_good: got %b want %b", outs, exp_v); end
    idx_pulse(); wait_clk(396);
    idx_pulse();
    exp_q.push_back(4'b1010);
    wait_clk(4);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL loss_relock: got %b want %b", outs, exp_v); end
    go_idle();
  endtask

  task automatic test_density();
    lock_300();
    u_if.spin_ss = 1'b1;
    exp_q.push_back(4'b1100);
    wait_clk(1);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL ss_switch: got %b want %b", outs, exp_v); end
    wait_clk(11);
    idx_pulse(); wait_clk(324);
    idx_pulse(); wait_clk(324);
    exp_q.push_back(4'b1100);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL ss_prelock: got %b want %b", outs, exp_v); end
    idx_pulse();
    exp_q.push_back(4'b1010);
    wait_clk(4);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL lock_360: got %b want %b", outs, exp_v); end
    exp_q.push_back(4'b1100);
    wait_clk(372);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL ss1_overrun: got %b want %b", outs, exp_v); end
    wait_clk(20);
    idx_pulse(); wait_clk(396);
    idx_pulse(); wait_clk(396);
    idx_pulse();
    exp_q.push_back(4'b1100);
    wait_clk(4);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL ss1_p100_nolock: got %b want %b", outs, exp_v); end
    go_idle();
  endtask

  task automatic test_disk_pull();
    u_if.motor_on_n = 1'b0; u_if.dsk_sens = 1'b1;
    exp_q.push_back(4'b1100);
    wait_clk(6);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL pull_spinup: got %b want %b", outs, exp_v); end
    u_if.dsk_sens = 1'b0;
    exp_q.push_back(4'b0100);
    wait_clk(4);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL disk_pull: got %b want %b", outs, exp_v); end
    go_idle();
  endtask

  task automatic test_async_reset();
    lock_300();
    wait_clk(10);
    #3 rst = 1'b0;
    exp_q.push_back(4'b0100);
    #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL async_reset: got %b want %b", outs, exp_v); end
    n_cmp++;
    if (u_if.state_dbg !== 2'd0) begin n_err++; $display("FAIL async_reset_state: got %0d want 0", u_if.state_dbg); end
    u_if.motor_on_n = 1'b1; u_if.dsk_sens = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    exp_q.push_back(4'b0100);
    wait_clk(4);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (outs !== exp_v) begin n_err++; $display("FAIL async_release: got %b want %b", outs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_lock_300();
    test_timeout();
    test_speed_loss();
    test_density();
    test_disk_pull();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
